ub_readout: RTL and testbench
=============================

UB_READOUT -- requirements
Module: ub_readout

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, buffer word address width.
REQ-002 SHALL have parameter BUFFER_WIDTH, default 64, buffer word width (ARRAY_SIZE x 16-bit lanes).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output FIFO depth; legal values are powers of 2 that are >= 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin a burst read.
REQ-007 SHALL have port base_addr, input, ADDR_WIDTH, first buffer word address, sampled with start.
REQ-008 SHALL have port num_words, input, ADDR_WIDTH, burst length in words, sampled with start.
REQ-009 SHALL have port abort, input, 1, cancels the active burst.
REQ-010 SHALL have port busy, output, 1, high while a burst is active.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port mem_rd_en, output, 1, buffer read strobe.
REQ-013 SHALL have port mem_rd_addr, output, ADDR_WIDTH, buffer read address.
REQ-014 SHALL have port mem_rd_data, input, BUFFER_WIDTH, buffer read data, valid exactly 1 cycle after mem_rd_en.
REQ-015 SHALL have port out_valid, output, 1, the host-side stream valid signal.
REQ-016 SHALL have port out_ready, input, 1, the host-side stream ready signal.
REQ-017 SHALL have port out_data, output, BUFFER_WIDTH, the stream data word.
REQ-018 SHALL have port out_last, output, 1, marking the final word of the burst.

Function
REQ-019 SHALL implement FSM states IDLE, READ (issuing reads), DRAIN (all reads issued, FIFO emptying).
REQ-020 SHALL, in IDLE with start=1 and num_words>0, latch base_addr/num_words and enter READ; busy=1 from the next cycle.
REQ-021 SHALL, on start with num_words=0, issue no reads, keep busy=0 and pulse done the following cycle.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL issue mem_rd_en only when (FIFO occupancy + reads in flight - pop this cycle) < FIFO_DEPTH; FIFO never overflows.
REQ-024 SHALL increment mem_rd_addr by 1 per issued read, wrapping modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000).
REQ-025 SHALL write mem_rd_data into the FIFO at the end of the cycle after each issued read.
REQ-026 SHALL have out_valid high whenever the FIFO is non-empty; out_data/out_last come from the FIFO head.
REQ-027 SHALL treat a word as transferred when out_valid & out_ready; out_data/out_last hold stable while out_valid & !out_ready.
REQ-028 SHALL have a first-word latency of 3 cycles: start sampled in cycle 0, mem_rd_en in cycle 1, out_valid in cycle 3.
REQ-029 SHALL sustain 1 word/cycle with out_ready held high once the first word is out.
REQ-030 SHALL set out_last=1 on exactly the num_words-th word only.
REQ-031 SHALL enter DRAIN from READ after the num_words-th read issues, and IDLE after the out_last transfer.
REQ-032 SHALL drop busy and pulse done for 1 cycle in the cycle after the out_last transfer.
REQ-033 SHALL, on abort while busy, enter IDLE next cycle, flush the FIFO, discard the in-flight read data, drop busy and out_valid, and not pulse done.
REQ-034 SHALL give abort priority over a simultaneous transfer; abort in IDLE has no effect.
REQ-035 SHALL allow a start in the cycle done pulses, and begin the new burst normally.

Reset
REQ-036 SHALL, while rst=1, force state IDLE, FIFO empty, in-flight count 0, and busy=done=mem_rd_en=out_valid=out_last=0, mem_rd_addr=0, out_data=0.
REQ-037 SHALL, on rst mid-burst, discard all pending data; no output resumes after rst is released until a new start.

Verification
REQ-038 SHALL cover: base_addr=0x0010, num_words=4, out_ready=1 -> reads 0x10..0x13 in cycles 1-4, words in cycles 3-6, out_last at cycle 6, done at cycle 7.
REQ-039 SHALL cover: num_words=8 with out_ready toggling 1,0 -> no FIFO overflow, in-order data, data held stable while stalled, exactly 8 transfers.
REQ-040 SHALL cover: base_addr=0xFFFE, num_words=4 -> read addresses FFFE, FFFF, 0000, 0001.
REQ-041 SHALL cover: num_words=0 -> no mem_rd_en, busy stays 0, done pulses in cycle 1.
REQ-042 SHALL cover: abort after 2 of 6 words -> out_valid=0 and busy=0 next cycle, no done, next start runs cleanly.
REQ-043 SHALL cover: rst asserted mid-burst with out_ready=0 -> all outputs at reset values, no stale words after release.

Source files
------------

// File: rtl/ub_readout_if.sv
// ub_readout host-side stream bundle.
// Word stream from the readout engine to the host.
interface ub_readout_if #(
    parameter int BUFFER_WIDTH = 64
);
    logic                    out_valid;
    logic                    out_ready;
    logic [BUFFER_WIDTH-1:0] out_data;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ub_readout.sv
// ub_readout: burst reader from the unified buffer into a
// small output FIFO feeding a valid/ready host stream.
module ub_readout #(
    parameter int ADDR_WIDTH   = 16,
    parameter int BUFFER_WIDTH = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH-1:0]   num_words,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [BUFFER_WIDTH-1:0] mem_rd_data,
    ub_readout_if.master            host
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW+1:0] DEPTH = (PW+2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   remain_q, remain_d;
    logic                    done_q, done_d;
    logic                    pend_q, pend_d;
    logic                    pend_last_q, pend_last_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW:0]             cnt_q, cnt_d;
    logic [BUFFER_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic                    fifo_last_q [FIFO_DEPTH];

    logic kill, valid, pop, push, room, issue;

    // Next-state, read issue, FIFO bookkeeping and output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        done_d      = 1'b0;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        issue       = 1'b0;

        kill  = abort && (state_q != IDLE);
        valid = (cnt_q != '0) && !rst;
        pop   = valid && host.out_ready;
        push  = pend_q && !kill;
        // A read may only issue if its word is guaranteed a slot,
        // counting the word still in flight and this cycle's pop.
        room  = ({1'b0, cnt_q} + {{(PW+1){1'b0}}, pend_q})
              < (DEPTH + {{(PW+1){1'b0}}, pop});

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d  = READ;
                        addr_d   = base_addr;
                        remain_d = num_words;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (room) begin
                    issue       = 1'b1;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remain_d    = remain_q - ADDR_WIDTH'(1);
                    pend_d      = 1'b1;
                    pend_last_d = (remain_q == ADDR_WIDTH'(1));
                    if (remain_q == ADDR_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_last_q[rd_ptr_q]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

        // Abort wins over everything, including a last-word pop.
        if (kill) begin
            state_d     = IDLE;
            remain_d    = '0;
            done_d      = 1'b0;
            pend_d      = 1'b0;
            pend_last_d = 1'b0;
            issue       = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
        end

        mem_rd_en      = issue && !rst;
        mem_rd_addr    = rst ? '0 : addr_q;
        busy           = (state_q != IDLE) && !rst;
        done           = done_q && !rst;
        host.out_valid = valid;
        host.out_data  = valid ? fifo_data_q[rd_ptr_q] : '0;
        host.out_last  = valid && fifo_last_q[rd_ptr_q];
    end

    // Control and FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // FIFO storage: captures returning read data one cycle after issue.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rd_data;
            fifo_last_q[wr_ptr_q] <= pend_last_q;
        end
    end

endmodule

// File: tb/tb_ub_readout.sv
// Self-checking bench for ub_readout: directed cycle tables
// plus randomized bursts against a queue-based stream model.
module tb_ub_readout;

    localparam int AW = 16;
    localparam int BW = 64;
    localparam int FD = 4;

    typedef struct {
        logic [BW-1:0] d;
        logic          l;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_words;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [BW-1:0] mem_rd_data;
    logic [31:0]   salt;

    int checks = 0;
    int fails  = 0;
    word_t exp_q[$];

    ub_readout_if #(.BUFFER_WIDTH(BW)) bus ();

    ub_readout #(
        .ADDR_WIDTH  (AW),
        .BUFFER_WIDTH(BW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .host       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a);
        return {salt, a, ~a};
    endfunction

    // Buffer model: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);
        else           mem_rd_data <= {$urandom, $urandom};
    end

    // Inputs are driven 2 time units after posedge,
    // outputs sampled 2 units later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        num_words = '0;
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        #2;
        checks++;
        if ({busy, done, mem_rd_en, bus.out_valid, bus.out_last} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {busy, done, mem_rd_en, bus.out_valid, bus.out_last});
        end
        checks++;
        if (mem_rd_addr !== '0 || bus.out_data !== '0) begin
            fails++;
            $display("FAIL reset_bus: addr %h data %h want 0", mem_rd_addr, bus.out_data);
        end
        cyc();
        rst = 1'b0;
    endtask

    task automatic run_table(input logic [AW-1:0] b, input string nm);
        logic exp_en, exp_v;
        logic [AW-1:0] ea;
        cyc();
        start = 1'b1;
        base_addr = b;
        num_words = 4;
        bus.out_ready = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_c0_busy: got %b want 0", nm, busy);
        end
        for (int c = 1; c <= 8; c++) begin
            cyc();
            start = 1'b0;
            #2;
            exp_en = (c >= 1 && c <= 4);
            exp_v  = (c >= 3 && c <= 6);
            ea = AW'(int'(b) + c - 1);
            checks++;
            if (mem_rd_en !== exp_en || (exp_en && mem_rd_addr !== ea)) begin
                fails++;
                $display("FAIL %s_rd c%0d: en %b addr %h want %b %h",
                         nm, c, mem_rd_en, mem_rd_addr, exp_en, ea);
            end
            ea = AW'(int'(b) + c - 3);
            checks++;
            if (bus.out_valid !== exp_v ||
                (exp_v && (bus.out_data !== mem_word(ea) || bus.out_last !== (c == 6)))) begin
                fails++;
                $display("FAIL %s_out c%0d: v %b d %h l %b want %b %h %b", nm, c,
                         bus.out_valid, bus.out_data, bus.out_last, exp_v, mem_word(ea), c == 6);
            end
            checks++;
            if (done !== (c == 7) || busy !== (c <= 6)) begin
                fails++;
                $display("FAIL %s_stat c%0d: done %b busy %b want %b %b",
                         nm, c, done, busy, c == 7, c <= 6);
            end
        end
    endtask

    task automatic test_basic();
        run_table(16'h0010, "basic");
    endtask

    task automatic test_wrap();
        run_table(16'hFFFE, "wrap");
    endtask

    task automatic test_zero_len();
        cyc();
        start = 1'b1;
        base_addr = AW'($urandom);
        num_words = '0;
        #2;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            start = 1'b0;
            #2;
            checks++;
            if (done !== (c == 1) || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
                fails++;
                $display("FAIL zero_len c%0d: done %b busy %b en %b want %b 0 0",
                         c, done, busy, mem_rd_en, c == 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int issued, popped, xfers, pop;
        logic seen_done, held_v, held_l;
        logic [BW-1:0] held;
        logic [AW-1:0] b;
        word_t w;
        issued = 0; popped = 0; xfers = 0;
        seen_done = 1'b0; held_v = 1'b0; held_l = 1'b0; held = '0;
        b = AW'($urandom);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back('{mem_word(AW'(int'(b) + i)), i == 7});
        cyc();
        start = 1'b1;
        base_addr = b;
        num_words = 8;
        bus.out_ready = 1'b1;
        #2;
        for (int c = 1; c < 80 && !seen_done; c++) begin
            cyc();
            start = (c == 3);
            base_addr = b + 16'h0100;
            num_words = 5;
            bus.out_ready = (c % 2 == 0);
            #2;
            pop = int'(bus.out_valid && bus.out_ready);
            if (mem_rd_en) begin
                checks++;
                if (issued - popped - pop >= FD || mem_rd_addr !== AW'(int'(b) + issued)) begin
                    fails++;
                    $display("FAIL bp_issue c%0d: outstanding %0d addr %h want <%0d %h",
                             c, issued - popped - pop, mem_rd_addr, FD, AW'(int'(b) + issued));
                end
                issued++;
            end
            if (held_v) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.out_last !== held_l) begin
                    fails++;
                    $display("FAIL bp_hold c%0d: v %b d %h want 1 %h", c, bus.out_valid, bus.out_data, held);
                end
            end
            held_v = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra c%0d: got %h want none", c, bus.out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (bus.out_data !== w.d || bus.out_last !== w.l) begin
                        fails++;
                        $display("FAIL bp_data c%0d: got %h/%b want %h/%b",
                                 c, bus.out_data, bus.out_last, w.d, w.l);
                    end
                end
                xfers++;
                popped++;
            end else if (bus.out_valid) begin
                held_v = 1'b1;
                held = bus.out_data;
                held_l = bus.out_last;
            end
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (xfers != 8 || issued != 8 || !seen_done) begin
            fails++;
            $display("FAIL bp_total: xfers %0d reads %0d done %b want 8 8 1", xfers, issued, seen_done);
        end
    endtask

    task automatic test_abort();
        int xfers, ab_c;
        logic [AW-1:0] b;
        xfers = 0;
        ab_c = 0;
        b = AW'($urandom);
        cyc();
        start = 1'b1;
        base_addr = b;
        num_words = 6;
        bus.out_ready = 1'b1;
        #2;
        for (int c = 1; c < 40 && ab_c == 0; c++) begin
            cyc();
            start = 1'b0;
            abort = (xfers == 2);
            if (abort) ab_c = c;
            #2;
            if (bus.out_valid && bus.out_ready) xfers++;
        end
        cyc();
        abort = 1'b0;
        #2;
        checks++;
        if (ab_c == 0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_next: at %0d v %b busy %b want 0 0", ab_c, bus.out_valid, busy);
        end
        for (int c = 0; c < 8; c++) begin
            cyc();
            #2;
            checks++;
            if (done !== 1'b0 || bus.out_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
                fails++;
                $display("FAIL abort_quiet: done %b v %b en %b want 0 0 0", done, bus.out_valid, mem_rd_en);
            end
        end
        b = AW'($urandom);
        cyc();
        start = 1'b1;
        base_addr = b;
        num_words = 2;
        #2;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            start = 1'b0;
            #2;
            checks++;
            if (bus.out_valid !== (c == 3 || c == 4) || done !== (c == 5) ||
                ((c == 3 || c == 4) && (bus.out_data !== mem_word(AW'(int'(b) + c - 3)) ||
                                        bus.out_last !== (c == 4)))) begin
                fails++;
                $display("FAIL abort_restart c%0d: v %b d %h l %b done %b",
                         c, bus.out_valid, bus.out_data, bus.out_last, done);
            end
        end
    endtask

    task automatic test_rst_mid();
        cyc();
        start = 1'b1;
        base_addr = AW'($urandom);
        num_words = 6;
        bus.out_ready = 1'b0;
        #2;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            start = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            cyc();
            rst = 1'b1;
            #2;
            checks++;
            if ({busy, done, mem_rd_en, bus.out_valid, bus.out_last} !== 5'b0 ||
                mem_rd_addr !== '0 || bus.out_data !== '0) begin
                fails++;
                $display("FAIL rst_mid: ctrl %b addr %h data %h want 0",
                         {busy, done, mem_rd_en, bus.out_valid, bus.out_last},
                         mem_rd_addr, bus.out_data);
            end
        end
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            #2;
            checks++;
            if ({busy, done, mem_rd_en, bus.out_valid} !== 4'b0) begin
                fails++;
                $display("FAIL rst_stale: ctrl %b want 0000", {busy, done, mem_rd_en, bus.out_valid});
            end
        end
    endtask

    task automatic test_back_to_back();
        int left, dn, n;
        logic [AW-1:0] b;
        word_t w;
        left = 6;
        dn = 0;
        exp_q.delete();
        for (int c = 0; c < 3000 && !(left == 0 && dn == 6); c++) begin
            cyc();
            start = 1'b0;
            abort = 1'b0;
            bus.out_ready = ($urandom_range(3) != 0);
            if (left > 0 && (c == 0 || done)) begin
                n = $urandom_range(1, 10);
                b = (left == 3) ? 16'hFFFB : AW'($urandom);
                start = 1'b1;
                base_addr = b;
                num_words = AW'(n);
                for (int i = 0; i < n; i++)
                    exp_q.push_back('{mem_word(AW'(int'(b) + i)), i == n - 1});
                left--;
            end else if (busy && $urandom_range(7) == 0) begin
                start = 1'b1;
                base_addr = AW'($urandom);
                num_words = AW'($urandom_range(1, 5));
            end
            #2;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_extra c%0d: got %h want none", c, bus.out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (bus.out_data !== w.d || bus.out_last !== w.l) begin
                        fails++;
                        $display("FAIL b2b_data c%0d: got %h/%b want %h/%b",
                                 c, bus.out_data, bus.out_last, w.d, w.l);
                    end
                end
            end
            if (done) dn++;
        end
        start = 1'b0;
        checks++;
        if (dn != 6 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_total: done %0d left words %0d want 6 0", dn, exp_q.size());
        end
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_backpressure();
        test_abort();
        test_rst_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
